// File: rtl/sequencer_pkg.sv
// Shared types and constants for the relay-computer instruction sequencer.
package sequencer_pkg;

  typedef enum logic [3:0] {
    F0, F1, E0, E1, G0, G1, G2, G3, G4, G5, HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_MOV8, OP_SETAB, OP_ALU, OP_LOAD, OP_STORE,
    OP_MOV16, OP_HALT, OP_INCXY, OP_GOTO, OP_ILLEGAL
  } opclass_t;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_D  = 3'd3;
  localparam logic [2:0] REG_M1 = 3'd4;
  localparam logic [2:0] REG_M2 = 3'd5;
  localparam logic [2:0] REG_X  = 3'd6;
  localparam logic [2:0] REG_Y  = 3'd7;

  localparam logic [1:0] WIDE_M  = 2'd0;
  localparam logic [1:0] WIDE_XY = 2'd1;
  localparam logic [1:0] WIDE_J  = 2'd2;

  localparam logic [2:0] ALU_IDLE = 3'b111;

  function automatic logic [7:0] regOneHot(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/sequencer_decode.sv
// Combinational instruction decoder: opcode class, register fields,
// GOTO condition bits and undefined-opcode flag.
module sequencer_decode
  import sequencer_pkg::*;
(
  input  logic [7:0] inst,
  output opclass_t   opClass,
  output logic [2:0] dstReg,
  output logic [2:0] srcReg,
  output logic [2:0] aluFn,
  output logic [7:0] immVal,
  output logic [3:0] gotoCond,
  output logic       gotoLdXY,
  output logic [1:0] wideSrc,
  output logic       wideToPc,
  output logic       illegal
);

  assign aluFn    = inst[2:0];
  assign immVal   = {{3{inst[4]}}, inst[4:0]};
  assign gotoCond = inst[4:1];
  assign gotoLdXY = inst[5];
  assign wideSrc  = inst[2:1];
  assign wideToPc = inst[3];
  assign illegal  = (opClass == OP_ILLEGAL);

  always_comb begin
    opClass = OP_ILLEGAL;
    dstReg  = '0;
    srcReg  = '0;
    casez (inst)
      8'b00??????: begin
        opClass = OP_MOV8;
        dstReg  = inst[5:3];
        srcReg  = inst[2:0];
      end
      8'b01??????: begin
        opClass = OP_SETAB;
        dstReg  = inst[5] ? REG_B : REG_A;
      end
      8'b1000????: begin
        opClass = OP_ALU;
        dstReg  = inst[3] ? REG_D : REG_A;
      end
      8'b100100??: begin
        opClass = OP_LOAD;
        dstReg  = {1'b0, inst[1:0]};
      end
      8'b100110??: begin
        opClass = OP_STORE;
        srcReg  = {1'b0, inst[1:0]};
      end
      // HALT occupies the d=1/ss=11 slot of MOV16; d=0/ss=11 is undefined
      8'b10101110: opClass = OP_HALT;
      8'b1010???0: opClass = (inst[2:1] == 2'b11) ? OP_ILLEGAL : OP_MOV16;
      8'b10110000: opClass = OP_INCXY;
      8'b11?????0: opClass = OP_GOTO;
      default:     opClass = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Self-running fetch/decode/execute control FSM for the relay computer.
// Define SEQ_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT instead of a NOP.
module instruction_sequencer
  import sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Inst,
  input  logic       zero,
  input  logic       carry,
  input  logic       sign,
  input  logic       resume,
  output logic       LdA, LdB, LdC, LdD, LdM1, LdM2, LdX, LdY, LdXY,
  output logic       SelA, SelB, SelC, SelD, SelM1, SelM2, SelX, SelY, SelM, SelXY,
  output logic       LdJ1, LdJ2, LdInst, LdPC, LdINC, LdCond, SelJ, SelPC, SelINC,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       SelImm,
  output logic [7:0] imm,
  output logic [2:0] AluFunctionCode,
  output logic       Halt,
  output logic       illegal
);

  state_t     state, nextState;
  logic       armed;
  opclass_t   opClass;
  logic [2:0] dstReg, srcReg, aluFn;
  logic [7:0] immVal;
  logic [3:0] gotoCond;
  logic       gotoLdXY, wideToPc, decIllegal, taken;
  logic [1:0] wideSrc;
  logic [7:0] ldReg, selReg;

  sequencer_decode uDecode (
    .inst     (Inst),
    .opClass  (opClass),
    .dstReg   (dstReg),
    .srcReg   (srcReg),
    .aluFn    (aluFn),
    .immVal   (immVal),
    .gotoCond (gotoCond),
    .gotoLdXY (gotoLdXY),
    .wideSrc  (wideSrc),
    .wideToPc (wideToPc),
    .illegal  (decIllegal)
  );

  // gotoCond = {s, c, z, n}
  assign taken = (gotoCond == 4'b0000) |
                 (gotoCond[3] & sign) | (gotoCond[2] & carry) |
                 (gotoCond[1] & zero) | (gotoCond[0] & ~zero);

  // armed holds outputs quiet until the first edge after reset release, which opens F0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= F0;
      armed <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else begin
      state <= nextState;
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic trapped;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trapped <= 1'b0;
    else if (armed && state == F1 && decIllegal) trapped <= 1'b1;
    else if (armed && state == HALT && resume) trapped <= 1'b0;
  end
`endif

  always_comb begin
    nextState = state;
    case (state)
      F0: nextState = F1;
      F1: begin
        nextState = E0;
        if (opClass == OP_GOTO) nextState = G0;
        else if (opClass == OP_HALT) nextState = HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
        else if (decIllegal) nextState = HALT;
`endif
      end
      E0:   nextState = (opClass == OP_INCXY) ? E1 : F0;
      E1:   nextState = F0;
      G0:   nextState = G1;
      G1:   nextState = G2;
      G2:   nextState = G3;
      G3:   nextState = taken ? (gotoLdXY ? G4 : G5) : F0;
      G4:   nextState = taken ? G5 : F0;
      G5:   nextState = F0;
      HALT: nextState = resume ? F0 : HALT;
      default: nextState = F0;
    endcase
  end

  always_comb begin
    ldReg = '0;  selReg = '0;
    LdXY = 1'b0; SelM = 1'b0; SelXY = 1'b0;
    LdJ1 = 1'b0; LdJ2 = 1'b0; LdInst = 1'b0; LdPC = 1'b0; LdINC = 1'b0; LdCond = 1'b0;
    SelJ = 1'b0; SelPC = 1'b0; SelINC = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; SelImm = 1'b0;
    imm = '0; AluFunctionCode = ALU_IDLE; Halt = 1'b0; illegal = 1'b0;
    if (armed) begin
      case (state)
        F0, G0, G2: begin
          SelPC = 1'b1; MemRead = 1'b1; LdINC = 1'b1;
          LdInst = (state == F0);
          LdJ1   = (state == G0);
          LdJ2   = (state == G2);
        end
        F1, G1, G3: begin SelINC = 1'b1; LdPC = 1'b1; end
        E0: begin
          case (opClass)
            OP_MOV8:  begin ldReg = regOneHot(dstReg); selReg = regOneHot(srcReg); end
            OP_SETAB: begin SelImm = 1'b1; imm = immVal; ldReg = regOneHot(dstReg); end
            OP_ALU:   begin AluFunctionCode = aluFn; LdCond = 1'b1; ldReg = regOneHot(dstReg); end
            OP_LOAD:  begin SelM = 1'b1; MemRead = 1'b1; ldReg = regOneHot(dstReg); end
            OP_STORE: begin SelM = 1'b1; MemWrite = 1'b1; selReg = regOneHot(srcReg); end
            OP_MOV16: begin
              SelM  = (wideSrc == WIDE_M);
              SelXY = (wideSrc == WIDE_XY);
              SelJ  = (wideSrc == WIDE_J);
              LdPC  = wideToPc;
              LdXY  = ~wideToPc;
            end
            OP_INCXY: begin SelXY = 1'b1; LdINC = 1'b1; end
            OP_ILLEGAL: illegal = 1'b1;
            default: ;
          endcase
        end
        E1: begin SelINC = 1'b1; LdXY = 1'b1; end
        G4: begin SelPC = 1'b1; LdXY = 1'b1; end
        G5: begin SelJ = 1'b1; LdPC = 1'b1; end
        HALT: begin
          Halt = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
          illegal = trapped;
`endif
        end
        default: ;
      endcase
    end
  end

  assign LdA   = ldReg[REG_A];   assign SelA  = selReg[REG_A];
  assign LdB   = ldReg[REG_B];   assign SelB  = selReg[REG_B];
  assign LdC   = ldReg[REG_C];   assign SelC  = selReg[REG_C];
  assign LdD   = ldReg[REG_D];   assign SelD  = selReg[REG_D];
  assign LdM1  = ldReg[REG_M1];  assign SelM1 = selReg[REG_M1];
  assign LdM2  = ldReg[REG_M2];  assign SelM2 = selReg[REG_M2];
  assign LdX   = ldReg[REG_X];   assign SelX  = selReg[REG_X];
  assign LdY   = ldReg[REG_Y];   assign SelY  = selReg[REG_Y];

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: per-instruction cycle lists
// built from the instruction-set rules, compared cycle by cycle.
module tb_instruction_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] Inst;
  logic zero, carry, sign, resume;
  logic LdA, LdB, LdC, LdD, LdM1, LdM2, LdX, LdY, LdXY;
  logic SelA, SelB, SelC, SelD, SelM1, SelM2, SelX, SelY, SelM, SelXY;
  logic LdJ1, LdJ2, LdInst, LdPC, LdINC, LdCond, SelJ, SelPC, SelINC;
  logic MemRead, MemWrite, SelImm, Halt, illegal;
  logic [7:0] imm;
  logic [2:0] AluFunctionCode;

  instruction_sequencer dut (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .zero(zero), .carry(carry), .sign(sign),
    .resume(resume),
    .LdA(LdA), .LdB(LdB), .LdC(LdC), .LdD(LdD), .LdM1(LdM1), .LdM2(LdM2), .LdX(LdX),
    .LdY(LdY), .LdXY(LdXY),
    .SelA(SelA), .SelB(SelB), .SelC(SelC), .SelD(SelD), .SelM1(SelM1), .SelM2(SelM2),
    .SelX(SelX), .SelY(SelY), .SelM(SelM), .SelXY(SelXY),
    .LdJ1(LdJ1), .LdJ2(LdJ2), .LdInst(LdInst), .LdPC(LdPC), .LdINC(LdINC), .LdCond(LdCond),
    .SelJ(SelJ), .SelPC(SelPC), .SelINC(SelINC),
    .MemRead(MemRead), .MemWrite(MemWrite), .SelImm(SelImm), .imm(imm),
    .AluFunctionCode(AluFunctionCode), .Halt(Halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Bit positions inside the observed strobe vector
  localparam int I_LDA = 0, I_LDXY = 8, I_SELA = 9, I_SELM = 17, I_SELXY = 18;
  localparam int I_LDJ1 = 19, I_LDJ2 = 20, I_LDINST = 21, I_LDPC = 22, I_LDINC = 23;
  localparam int I_LDCOND = 24, I_SELJ = 25, I_SELPC = 26, I_SELINC = 27;
  localparam int I_MEMRD = 28, I_MEMWR = 29, I_SELIMM = 30, I_HALT = 31, I_ILL = 32;
  localparam logic [2:0] IDLE = 3'b111;

  logic [43:0] obs;
  assign obs = {illegal, Halt, SelImm, MemWrite, MemRead, SelINC, SelPC, SelJ, LdCond,
                LdINC, LdPC, LdInst, LdJ2, LdJ1, SelXY, SelM, SelY, SelX, SelM2, SelM1,
                SelD, SelC, SelB, SelA, LdXY, LdY, LdX, LdM2, LdM1, LdD, LdC, LdB, LdA,
                AluFunctionCode, imm};

  int checks = 0;
  int passed = 0;
  logic [43:0] expq[$];

  function automatic logic [32:0] b(input int i);
    return 33'd1 << i;
  endfunction

  function automatic logic [43:0] cyc(input logic [32:0] s, input logic [2:0] a,
                                      input logic [7:0] im);
    return {s, a, im};
  endfunction

  function automatic logic [43:0] fetch0();
    return cyc(b(I_SELPC) | b(I_MEMRD) | b(I_LDINST) | b(I_LDINC), IDLE, 8'h00);
  endfunction

  function automatic logic [43:0] fetch1();
    return cyc(b(I_SELINC) | b(I_LDPC), IDLE, 8'h00);
  endfunction

  // Expected cycle list for one instruction; halts=1 when it ends in HALT
  task automatic buildExp(input logic [7:0] in, input logic z, input logic c,
                          input logic sg, output bit halts);
    bit ill;
    bit tk;
    int sel, ld;
    expq.delete();
    halts = 0;
    ill = 0;
    expq.push_back(fetch0());
    expq.push_back(fetch1());
    casez (in)
      8'b00??????: expq.push_back(cyc(b(I_LDA + int'(in[5:3])) | b(I_SELA + int'(in[2:0])),
                                      IDLE, 8'h00));
      8'b01??????: expq.push_back(cyc(b(I_SELIMM) | b(in[5] ? 1 : 0), IDLE,
                                      {{3{in[4]}}, in[4:0]}));
      8'b1000????: expq.push_back(cyc(b(I_LDCOND) | b(in[3] ? 3 : 0), in[2:0], 8'h00));
      8'b100100??: expq.push_back(cyc(b(I_SELM) | b(I_MEMRD) | b(int'(in[1:0])), IDLE, 8'h00));
      8'b100110??: expq.push_back(cyc(b(I_SELM) | b(I_MEMWR) | b(I_SELA + int'(in[1:0])),
                                      IDLE, 8'h00));
      8'b10101110: halts = 1;
      8'b1010???0: begin
        if (in[2:1] == 2'b11) ill = 1;
        else begin
          sel = (in[2:1] == 2'b00) ? I_SELM : (in[2:1] == 2'b01) ? I_SELXY : I_SELJ;
          ld  = in[3] ? I_LDPC : I_LDXY;
          expq.push_back(cyc(b(sel) | b(ld), IDLE, 8'h00));
        end
      end
      8'b10110000: begin
        expq.push_back(cyc(b(I_SELXY) | b(I_LDINC), IDLE, 8'h00));
        expq.push_back(cyc(b(I_SELINC) | b(I_LDXY), IDLE, 8'h00));
      end
      8'b11?????0: begin
        tk = (in[4:1] == 4'b0000) || (in[4] && sg) || (in[3] && c) || (in[2] && z) ||
             (in[1] && !z);
        expq.push_back(cyc(b(I_SELPC) | b(I_MEMRD) | b(I_LDJ1) | b(I_LDINC), IDLE, 8'h00));
        expq.push_back(cyc(b(I_SELINC) | b(I_LDPC), IDLE, 8'h00));
        expq.push_back(cyc(b(I_SELPC) | b(I_MEMRD) | b(I_LDJ2) | b(I_LDINC), IDLE, 8'h00));
        expq.push_back(cyc(b(I_SELINC) | b(I_LDPC), IDLE, 8'h00));
        if (tk && in[5]) expq.push_back(cyc(b(I_SELPC) | b(I_LDXY), IDLE, 8'h00));
        if (tk) expq.push_back(cyc(b(I_SELJ) | b(I_LDPC), IDLE, 8'h00));
      end
      default: ill = 1;
    endcase
    if (ill) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      halts = 1;
`else
      expq.push_back(cyc(b(I_ILL), IDLE, 8'h00));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== cyc('0, IDLE, 8'h00))
      $display("FAIL reset_hold got=%011h exp=%011h", obs, cyc('0, IDLE, 8'h00));
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== cyc('0, IDLE, 8'h00))
      $display("FAIL reset_release got=%011h exp=%011h", obs, cyc('0, IDLE, 8'h00));
    else passed++;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] tbl[9] = '{8'h0B, 8'h5F, 8'h81, 8'h93, 8'h99, 8'hA4, 8'hAA, 8'hB0, 8'h3F};
    bit h;
    foreach (tbl[i]) begin
      Inst = tbl[i];
      {zero, carry, sign} = 3'($urandom);
      buildExp(Inst, zero, carry, sign, h);
      for (int k = 0; k < expq.size(); k++) begin
        checks++;
        if (obs !== expq[k])
          $display("FAIL basic cycle %0d inst=%02h got=%011h exp=%011h", k, Inst, obs, expq[k]);
        else passed++;
        step();
      end
    end
    checks++;
    if (obs !== fetch0()) $display("FAIL basic_next_f0 got=%011h exp=%011h", obs, fetch0());
    else passed++;
  endtask

  task automatic test_goto();
    logic [7:0] gi[5] = '{8'hE4, 8'hE4, 8'hC0, 8'hD2, 8'hE8};
    logic [2:0] gf[5] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b010}; // {zero,carry,sign}
    bit h;
    foreach (gi[i]) begin
      Inst = gi[i];
      {zero, carry, sign} = gf[i];
      buildExp(Inst, zero, carry, sign, h);
      for (int k = 0; k < expq.size(); k++) begin
        checks++;
        if (obs !== expq[k])
          $display("FAIL goto cycle %0d inst=%02h got=%011h exp=%011h", k, Inst, obs, expq[k]);
        else passed++;
        step();
      end
    end
  endtask

  task automatic test_halt();
    resume = 1'b0;
    Inst = 8'hAE;
    checks++;
    if (obs !== fetch0()) $display("FAIL halt_f0 got=%011h exp=%011h", obs, fetch0());
    else passed++;
    step();
    checks++;
    if (obs !== fetch1()) $display("FAIL halt_f1 got=%011h exp=%011h", obs, fetch1());
    else passed++;
    step();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (obs !== cyc(b(I_HALT), IDLE, 8'h00))
        $display("FAIL halt_hold cycle %0d got=%011h exp=%011h", k, obs, cyc(b(I_HALT), IDLE, 8'h00));
      else passed++;
      step();
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++;
    if (obs !== fetch0()) $display("FAIL halt_resume got=%011h exp=%011h", obs, fetch0());
    else passed++;
  endtask

  task automatic test_illegal();
    logic [7:0] il[3] = '{8'h94, 8'hFF, 8'hA6};
    bit h;
    foreach (il[i]) begin
      Inst = il[i];
      buildExp(Inst, zero, carry, sign, h);
      for (int k = 0; k < expq.size(); k++) begin
        checks++;
        if (obs !== expq[k])
          $display("FAIL illegal cycle %0d inst=%02h got=%011h exp=%011h", k, Inst, obs, expq[k]);
        else passed++;
        step();
      end
      if (h) begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (obs !== cyc(b(I_HALT) | b(I_ILL), IDLE, 8'h00))
            $display("FAIL illegal_trap cycle %0d got=%011h exp=%011h", k, obs,
                     cyc(b(I_HALT) | b(I_ILL), IDLE, 8'h00));
          else passed++;
          step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++;
        if (obs !== fetch0()) $display("FAIL illegal_resume got=%011h exp=%011h", obs, fetch0());
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit h;
    Inst = 8'hE4;
    zero = 1'b1;
    buildExp(Inst, zero, carry, sign, h);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs !== expq[k])
        $display("FAIL reset_mid_pre cycle %0d got=%011h exp=%011h", k, obs, expq[k]);
      else passed++;
      if (k < 4) step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== cyc('0, IDLE, 8'h00))
      $display("FAIL reset_mid_async got=%011h exp=%011h", obs, cyc('0, IDLE, 8'h00));
    else passed++;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== fetch0()) $display("FAIL reset_mid_f0 got=%011h exp=%011h", obs, fetch0());
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit h;
    for (int n = 0; n < 60; n++) begin
      do begin
        Inst = 8'($urandom);
        {zero, carry, sign} = 3'($urandom);
        buildExp(Inst, zero, carry, sign, h);
      end while (h);
      resume = 1'($urandom);
      for (int k = 0; k < expq.size(); k++) begin
        checks++;
        if (obs !== expq[k])
          $display("FAIL random cycle %0d inst=%02h got=%011h exp=%011h", k, Inst, obs, expq[k]);
        else passed++;
        step();
      end
    end
    resume = 1'b0;
  endtask

  initial begin
    Inst = 8'h00;
    zero = 1'b0; carry = 1'b0; sign = 1'b0; resume = 1'b0;
    test_reset();
    test_basic();
    test_goto();
    test_halt();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d", passed, checks);
    $fatal(1, "timeout");
  end

endmodule
